// File: rtl/dtcm_lsu_ctrl.sv
// Data-TCM controller sitting directly behind the core LSU port.
// Checks range and alignment, runs loads and stores in one SRAM cycle, and runs
// AMOs as a read / modify-write / respond sequence on a single-port SRAM.
// Optional build macro: DTCM_LRSC_EN adds LR/SC with a one-word reservation.

typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  amo;
    logic [1:0]  size;
    logic [3:0]  strb;
} lsu_req_t;

typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
} lsu_ack_t;

module dtcm_lsu_ctrl #(
    parameter logic [31:0] DTCM_BASE_ADDR = 32'h8009_0000,
    parameter logic [31:0] DTCM_BYTES     = 32'h0001_0000,
    parameter int unsigned SRAM_AW        = 14
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  lsu_req_t           lsu_req_i,
    output lsu_ack_t           lsu_ack_o,
    output logic               sram_en_o,
    output logic               sram_we_o,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [3:0]         sram_be_o,
    output logic [31:0]        sram_wdata_o,
    input  logic [31:0]        sram_rdata_i
);

    localparam logic [3:0] AMO_NONE = 4'b0000;
    localparam logic [3:0] AMO_SWAP = 4'b0001;
    localparam logic [3:0] AMO_ADD  = 4'b0010;
    localparam logic [3:0] AMO_XOR  = 4'b0011;
    localparam logic [3:0] AMO_AND  = 4'b0100;
    localparam logic [3:0] AMO_OR   = 4'b0101;
    localparam logic [3:0] AMO_MIN  = 4'b0110;
    localparam logic [3:0] AMO_MAX  = 4'b0111;
    localparam logic [3:0] AMO_MINU = 4'b1000;
    localparam logic [3:0] AMO_MAXU = 4'b1001;
`ifdef DTCM_LRSC_EN
    localparam logic [3:0] AMO_LR   = 4'b1010;
    localparam logic [3:0] AMO_SC   = 4'b1011;
    localparam logic [3:0] AMO_LAST = AMO_SC;
`else
    localparam logic [3:0] AMO_LAST = AMO_MAXU;
`endif

    typedef enum logic [1:0] {IDLE, AMO_WR, RESP} state_e;
    // Source of rdata in the response cycle.
    typedef enum logic [1:0] {RS_ZERO, RS_SRAM, RS_OLD, RS_ONE} rsel_e;

    // New memory word for an AMO; MIN/MAX signed, MINU/MAXU unsigned, ADD wraps.
    function automatic logic [31:0] amo_calc(input logic [3:0] op,
                                             input logic [31:0] old_w,
                                             input logic [31:0] opnd);
        logic signed [31:0] s_old;
        logic signed [31:0] s_opnd;
        s_old  = old_w;
        s_opnd = opnd;
        case (op)
            AMO_SWAP: amo_calc = opnd;
            AMO_ADD:  amo_calc = old_w + opnd;
            AMO_XOR:  amo_calc = old_w ^ opnd;
            AMO_AND:  amo_calc = old_w & opnd;
            AMO_OR:   amo_calc = old_w | opnd;
            AMO_MIN:  amo_calc = (s_old < s_opnd) ? old_w : opnd;
            AMO_MAX:  amo_calc = (s_old > s_opnd) ? old_w : opnd;
            AMO_MINU: amo_calc = (old_w < opnd) ? old_w : opnd;
            AMO_MAXU: amo_calc = (old_w > opnd) ? old_w : opnd;
            default:  amo_calc = opnd;
        endcase
    endfunction

    state_e             state_q, state_d;
    rsel_e              rsel_q, rsel_d;
    logic               err_q, err_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         amo_q, amo_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [31:0]        old_q, old_d;
`ifdef DTCM_LRSC_EN
    logic               res_vld_q, res_vld_d;
    logic [SRAM_AW-1:0] res_addr_q, res_addr_d;
    logic               res_hit;
`endif

    logic [31:0]        req_off;
    logic               range_err;
    logic               misalign;
    logic               req_err;
    logic [SRAM_AW-1:0] req_word;

    // Request checks on the incoming request (only acted on in IDLE).
    always_comb begin
        req_off   = lsu_req_i.addr - DTCM_BASE_ADDR;
        range_err = (req_off >= DTCM_BYTES);
        req_word  = lsu_req_i.addr[SRAM_AW+1:2];
        case (lsu_req_i.size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = lsu_req_i.addr[0];
            2'b10:   misalign = |lsu_req_i.addr[1:0];
            default: misalign = 1'b1;
        endcase
        req_err = range_err | misalign | (lsu_req_i.amo > AMO_LAST) |
                  ((lsu_req_i.amo != AMO_NONE) && (lsu_req_i.size != 2'b10));
    end

`ifdef DTCM_LRSC_EN
    assign res_hit = res_vld_q && (res_addr_q == req_word);
`endif

    // Next-state, SRAM drive and response generation.
    always_comb begin
        state_d      = state_q;
        rsel_d       = rsel_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        amo_d        = amo_q;
        addr_d       = addr_q;
        old_d        = old_q;
`ifdef DTCM_LRSC_EN
        res_vld_d    = res_vld_q;
        res_addr_d   = res_addr_q;
`endif
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = req_word;
        sram_be_o    = 4'h0;
        sram_wdata_o = lsu_req_i.wdata;
        lsu_ack_o    = '0;

        case (state_q)
            IDLE: begin
                if (lsu_req_i.req) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rsel_d  = RS_ZERO;
                    if (req_err) begin
                        err_d = 1'b1;
                    end else if (lsu_req_i.amo == AMO_NONE) begin
                        sram_en_o = 1'b1;
                        sram_we_o = lsu_req_i.we;
                        sram_be_o = lsu_req_i.we ? lsu_req_i.strb : 4'hF;
                        if (!lsu_req_i.we) begin
                            rsel_d = RS_SRAM;
                        end
`ifdef DTCM_LRSC_EN
                        if (lsu_req_i.we && res_hit) begin
                            res_vld_d = 1'b0;
                        end
`endif
                    end
`ifdef DTCM_LRSC_EN
                    else if (lsu_req_i.amo == AMO_LR) begin
                        sram_en_o  = 1'b1;
                        sram_be_o  = 4'hF;
                        rsel_d     = RS_SRAM;
                        res_vld_d  = 1'b1;
                        res_addr_d = req_word;
                    end else if (lsu_req_i.amo == AMO_SC) begin
                        res_vld_d = 1'b0;
                        if (res_hit) begin
                            sram_en_o = 1'b1;
                            sram_we_o = 1'b1;
                            sram_be_o = 4'hF;
                        end else begin
                            rsel_d = RS_ONE;
                        end
                    end
`endif
                    else begin
                        // AMO read phase; operands held for the write phase.
                        sram_en_o = 1'b1;
                        sram_be_o = 4'hF;
                        wdata_d   = lsu_req_i.wdata;
                        amo_d     = lsu_req_i.amo;
                        addr_d    = req_word;
                        state_d   = AMO_WR;
`ifdef DTCM_LRSC_EN
                        if (res_hit) begin
                            res_vld_d = 1'b0;
                        end
`endif
                    end
                end
            end
            AMO_WR: begin
                old_d        = sram_rdata_i;
                sram_en_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_be_o    = 4'hF;
                sram_addr_o  = addr_q;
                sram_wdata_o = amo_calc(amo_q, sram_rdata_i, wdata_q);
                rsel_d       = RS_OLD;
                state_d      = RESP;
            end
            RESP: begin
                lsu_ack_o.ack   = 1'b1;
                lsu_ack_o.error = err_q;
                case (rsel_q)
                    RS_SRAM: lsu_ack_o.rdata = sram_rdata_i;
                    RS_OLD:  lsu_ack_o.rdata = old_q;
                    RS_ONE:  lsu_ack_o.rdata = 32'd1;
                    default: lsu_ack_o.rdata = 32'd0;
                endcase
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset abandons an in-flight AMO write and suppresses any ack.
        if (rst_i) begin
            sram_en_o = 1'b0;
            sram_we_o = 1'b0;
            lsu_ack_o = '0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rsel_q  <= RS_ZERO;
            err_q   <= 1'b0;
`ifdef DTCM_LRSC_EN
            res_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rsel_q  <= rsel_d;
            err_q   <= err_d;
`ifdef DTCM_LRSC_EN
            res_vld_q <= res_vld_d;
`endif
        end
    end

    // Datapath holding registers, no reset needed.
    always_ff @(posedge clk_i) begin
        wdata_q <= wdata_d;
        amo_q   <= amo_d;
        addr_q  <= addr_d;
        old_q   <= old_d;
`ifdef DTCM_LRSC_EN
        res_addr_q <= res_addr_d;
`endif
    end

endmodule

// File: doc/dtcm_lsu_ctrl.md
Name: dtcm_lsu_ctrl

Overview:
- Data-TCM controller directly downstream of the core LSU port.
- Consumes lsu_req_t requests and returns lsu_ack_t responses.
- Drives a single-port, 1-cycle-read-latency SRAM holding the DTCM region.
- Performs range and alignment checks; executes atomic memory operations (AMOs) as an internal read-modify-write sequence.

Parameters:
- DTCM_BASE_ADDR, 32'h8009_0000, first byte address of the DTCM window.
- DTCM_BYTES, 32'h0001_0000, window size in bytes; must be a power of two.
- SRAM_AW, 14, SRAM word-address width; must equal log2(DTCM_BYTES/4).

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; synchronous, active-high.
- lsu_req_i  in  lsu_req_t  fields: req, we, addr[31:0], wdata[31:0], amo[3:0], size[1:0], strb[3:0].
- lsu_ack_o  out  lsu_ack_t  fields: ack, error, rdata[31:0].
- sram_en_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  SRAM_AW  SRAM word address, equal to addr[SRAM_AW+1:2].
- sram_be_o  out  4  SRAM byte enables.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data, valid the cycle after a read enable.

Behaviour:
- Reset state: lsu_ack_o = all zero, sram_en_o = 0, sram_we_o = 0, FSM = IDLE, reservation invalid.
- Reset mid-operation: any pending AMO write is abandoned and no ack is issued.
- Handshake:
  - Core holds req and all fields stable until it sees ack.
  - ack is a single-cycle pulse.
  - req is sampled only in IDLE, so a req still high during the ack cycle is not re-accepted.
  - Back-to-back requests: a new request is accepted the cycle after ack.
- Request checks, evaluated combinationally in IDLE:
  - Range error: (addr − DTCM_BASE_ADDR) ≥ DTCM_BYTES, computed unsigned.
  - Misalignment error: size=01 with addr[0]=1; size=10 with addr[1:0]≠0; size=11 always.
  - AMO requests (amo≠0) additionally require size=10.
  - Unknown amo code: error.
  - On any error: no SRAM access; ack=1, error=1, rdata=0 one cycle after acceptance.
- SRAM is driven combinationally from lsu_req_i in IDLE for the first access.
- AMO codes: 0000 none; 0001 SWAP; 0010 ADD; 0011 XOR; 0100 AND; 0101 OR; 0110 MIN; 0111 MAX; 1000 MINU; 1001 MAXU. 1010 LR and 1011 SC exist only with the optional feature.
- Load (we=0, amo=0):
  - Cycle 0: en=1, we=0, be=4'hF.
  - Cycle 1: ack with rdata = raw sram_rdata_i word; byte/half extraction and sign extension are done by the LSU.
  - Latency 1 cycle.
- Store (we=1, amo=0):
  - Cycle 0: en=1, we=1, be=strb, wdata=wdata.
  - Cycle 1: ack, rdata=0.
- AMO FSM: IDLE → AMO_WR → RESP → IDLE.
  - Cycle 0 (IDLE): read with en=1, we=0; request fields latched.
  - Cycle 1 (AMO_WR): old = sram_rdata_i; write f(old, wdata) with be=4'hF.
  - Cycle 2 (RESP): ack, rdata = old. Latency 2 cycles.
  - ADD wraps modulo 2^32.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned.
  - The we field is ignored for AMOs.
- Error flag: only set for range, alignment, or unknown-amo failures. SRAM has no error input.

Optional Feature:
- Macro: DTCM_LRSC_EN.
- With the macro: a 1-bit reservation valid plus a reservation word address is maintained.
  - LR (1010): behaves as a load; sets reservation to addr[SRAM_AW+1:2].
  - SC (1011), reservation valid and address matching: write with be=F; ack next cycle with rdata=0.
  - SC otherwise: no write; ack next cycle with rdata=1.
  - Every SC clears the reservation.
  - Any store or AMO hitting the reserved word clears it.
  - Reset clears it.
- Without the macro: codes 1010 and 1011 are unknown and return the error ack. No reservation state exists.

Test Plan:
- Word store then load: store addr=0x8009_0010, wdata=0xDEADBEEF, strb=F → ack at +1, error=0. Load same addr → ack at +1, rdata=0xDEADBEEF, sram_addr_o=0x004.
- Byte store: store strb=4'b0100, wdata=0x00AA0000 to the word above → be=0100 on SRAM. Reload returns 0xDEAABEEF.
- AMO ADD: word holds 0xFFFF_FFFF; AMOADD with wdata=2 → ack at +2, rdata=0xFFFF_FFFF; memory becomes 0x0000_0001. AMOMIN with wdata=0x8000_0000 → memory 0x8000_0000. AMOMAXU with wdata=0x8000_0000 on 0x1 → memory 0x8000_0000.
- Errors, each with no sram_en_o pulse and ack at +1 with error=1: addr=0x8008_FFFC (below base); addr=0x800A_0000 (above end); word load at 0x8009_0002; AMO with size=00.
- Reset during AMO_WR: rst_i asserted in cycle 1 of an AMO → no SRAM write, no ack, FSM in IDLE, next load accepted normally.
- LR/SC (DTCM_LRSC_EN): LR 0x8009_0020 then SC → rdata=0, written. Second SC → rdata=1, no write. LR, store to the same word, then SC → rdata=1. Without the macro, LR → error=1.
